isolde_rf_write_arbiter: RTL and testbench
==========================================

// Module: isolde_rf_write_arbiter
// PURPOSE
//  Shares the single write port (we_0/waddr_0/wdata_0) of the ISOLDE quad-word register
//  file between NumReq writers: decoder vector load, exec writeback, redmule result.
//  Round-robin grant, one registered write per cycle.
//  Also keeps a destination scoreboard: the decoder claims a register at issue, and the
//  matching write releases it. The decoder stalls on busy registers (RAW/WAW).
// PARAMETERS
//  NumReq     3    number of write requesters (>=2); index 0 = decoder load
//  AddrWidth  5    register address width; scoreboard holds 2**AddrWidth bits
//  DataWidth  128  write data width (4 x 32-bit words, word[3] = MSW)
// PORTS
//  clk_i          in   1                    clock, all state on rising edge
//  rst_ni         in   1                    reset, asynchronous, active-low
//  req_valid_i    in   NumReq               requester i has a write pending
//  req_addr_i     in   NumReq*AddrWidth     destination register per requester
//  req_data_i     in   NumReq*DataWidth     write data per requester
//  req_ready_o    out  NumReq               one-hot grant; request accepted this cycle
//  claim_valid_i  in   1                    decoder reserves claim_addr_i at issue
//  claim_addr_i   in   AddrWidth            register being reserved
//  claim_ready_o  out  1                    claim accepted (target not busy)
//  chk_addr_i     in   2*AddrWidth          two source registers checked by the decoder
//  chk_busy_o     out  2                    bit k = busy[chk_addr_i[k]], combinational
//  flush_i        in   1                    drop all reservations and block new grants
//  rf_we_o        out  1                    register-file write enable (to we_0)
//  rf_waddr_o     out  AddrWidth            write address (to waddr_0)
//  rf_wdata_o     out  DataWidth            write data (to wdata_0)
//  busy_o         out  2**AddrWidth         scoreboard, for debug and stall logic
// BEHAVIOUR
//  Reset (async, rst_ni=0)
//   - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, rr_ptr=0.
//   - req_ready_o=0 and claim_ready_o=0 while rst_ni=0.
//   - Reset mid-transfer drops the registered write; it is never replayed.
//  Arbitration (combinational grant, registered output)
//   - Pick the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NumReq.
//   - req_ready_o = one-hot of the winner; all zero if no valid or flush_i=1.
//   - A request is transferred when req_valid_i[i] & req_ready_o[i].
//   - Requesters hold valid/addr/data stable until ready. Valid may not drop without a grant.
//   - On a transfer by requester w: rr_ptr <= (w+1) mod NumReq; else rr_ptr holds.
//   - Next edge after a transfer: rf_we_o=1 with that addr/data, for exactly 1 cycle.
//   - No transfer: rf_we_o <= 0; rf_waddr_o/rf_wdata_o hold their last value.
//   - Latency is 1 cycle, throughput 1 write/cycle. The register file always accepts.
//   - Worst-case wait for any requester is NumReq-1 grants (starvation-free).
//  Scoreboard
//   - claim_ready_o = claim_valid_i & ~busy[claim_addr_i] & ~flush_i.
//   - An accepted claim sets busy[claim_addr_i] at the next edge.
//   - rf_we_o=1 clears busy[rf_waddr_o] at that edge.
//   - Writes to a non-busy register are legal and leave the scoreboard unchanged.
//   - Same-edge set and clear on the same address: the set wins (busy stays 1).
//   - chk_busy_o reads the current busy_o; there is no bypass of a same-cycle clear.
//  Flush
//   - flush_i=1: busy_o <= 0 at the edge; no new grant or claim in that cycle.
//   - A write already registered (rf_we_o=1 in the flush cycle) still completes.
//   - rr_ptr is unchanged by flush.
// TESTING
//  1 Reset: assert rst_ni=0 mid-write (rf_we_o=1) -> rf_we_o and busy_o drop to 0 at once,
//    without waiting for a clock edge.
//  2 Single write: req0 valid, addr=5, data=128'h0123..CDEF -> ready0 in cycle 0;
//    next cycle rf_we_o=1, rf_waddr_o=5, data matches; rf_we_o=0 the cycle after.
//  3 Fairness: all three requesters held valid for 6 cycles, rr_ptr=0 ->
//    grant order 0,1,2,0,1,2; rf_we_o=1 on 6 consecutive cycles.
//  4 Scoreboard: claim r7 -> busy_o[7]=1, and chk_addr=7 gives chk_busy=1.
//    A second claim of r7 gives claim_ready_o=0. Exec writes r7 -> busy_o[7]=0
//    one cycle after rf_we_o.
//  5 Collision: claim r3 in the same cycle rf_we_o=1 with waddr=3 -> busy_o[3]=1 afterwards.
//  6 Flush: busy r2 and r9 set, req1 valid, flush_i=1 for 1 cycle -> ready=0,
//    claim_ready=0, busy_o=0 next cycle. req1 is granted in the following cycle.

Source files
------------

// File: rtl/isolde_rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus the
// destination scoreboard the decoder uses to stall on busy registers.
module isolde_rf_write_arbiter #(
    parameter int NumReq    = 3,
    parameter int AddrWidth = 5,
    parameter int DataWidth = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic                          claim_valid_i,
    input  logic [AddrWidth-1:0]          claim_addr_i,
    output logic                          claim_ready_o,
    input  logic [2*AddrWidth-1:0]        chk_addr_i,
    output logic [1:0]                    chk_busy_o,
    input  logic                          flush_i,
    output logic                          rf_we_o,
    output logic [AddrWidth-1:0]          rf_waddr_o,
    output logic [DataWidth-1:0]          rf_wdata_o,
    output logic [2**AddrWidth-1:0]       busy_o
);

    localparam int PtrW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int NumRegs = 2**AddrWidth;

    logic [PtrW-1:0]      rr_ptr;
    logic [PtrW-1:0]      win;
    logic [PtrW-1:0]      win_next;
    logic [PtrW:0]        scan;
    logic                 found;
    logic                 xfer;
    logic [NumRegs-1:0]   busy_q;
    logic [NumRegs-1:0]   busy_d;

    logic [AddrWidth-1:0] addr_arr [NumReq];
    logic [DataWidth-1:0] data_arr [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*AddrWidth +: AddrWidth];
        assign data_arr[g] = req_data_i[g*DataWidth +: DataWidth];
    end

    // Scan rr_ptr, rr_ptr+1, ... modulo NumReq and take the first valid requester.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        scan        = '0;
        found       = 1'b0;
        win         = '0;
        req_ready_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            scan = {1'b0, rr_ptr} + (PtrW+1)'(k);
            if (scan >= (PtrW+1)'(NumReq)) scan = scan - (PtrW+1)'(NumReq);
            if (!found && req_valid_i[scan[PtrW-1:0]]) begin
                found = 1'b1;
                win   = scan[PtrW-1:0];
            end
        end
        if (found && rst_ni && !flush_i) req_ready_o[win] = 1'b1;
    end

    assign xfer     = |req_ready_o;
    assign win_next = (win == PtrW'(NumReq-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            rr_ptr     <= '0;
        end else begin
            rf_we_o <= xfer;
            if (xfer) begin
                rf_waddr_o <= addr_arr[win];
                rf_wdata_o <= data_arr[win];
                rr_ptr     <= win_next;
            end
        end
    end

    assign claim_ready_o = rst_ni & claim_valid_i & ~busy_q[claim_addr_i] & ~flush_i;

    // The clear of a completing write is applied first so a same-edge claim wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_o)       busy_d[rf_waddr_o]   = 1'b0;
        if (claim_ready_o) busy_d[claim_addr_i] = 1'b1;
        if (flush_i)       busy_d               = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset to "nothing busy".
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o        = busy_q;
    assign chk_busy_o[0] = busy_q[chk_addr_i[0 +: AddrWidth]];
    assign chk_busy_o[1] = busy_q[chk_addr_i[AddrWidth +: AddrWidth]];

endmodule

// File: tb/tb_isolde_rf_write_arbiter.sv
// Directed bench for isolde_rf_write_arbiter: reset, single write, fairness,
// scoreboard claim/release, claim/clear collision and flush.
module tb_isolde_rf_write_arbiter;

    localparam int NumReq    = 3;
    localparam int AddrWidth = 5;
    localparam int DataWidth = 128;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic [NumReq-1:0]           req_valid;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [NumReq-1:0]           req_ready;
    logic                        claim_valid;
    logic [AddrWidth-1:0]        claim_addr;
    logic                        claim_ready;
    logic [2*AddrWidth-1:0]      chk_addr;
    logic [1:0]                  chk_busy;
    logic                        flush;
    logic                        rf_we;
    logic [AddrWidth-1:0]        rf_waddr;
    logic [DataWidth-1:0]        rf_wdata;
    logic [2**AddrWidth-1:0]     busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    isolde_rf_write_arbiter #(
        .NumReq   (NumReq),
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .claim_valid_i(claim_valid),
        .claim_addr_i (claim_addr),
        .claim_ready_o(claim_ready),
        .chk_addr_i   (chk_addr),
        .chk_busy_o   (chk_busy),
        .flush_i      (flush),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .busy_o       (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [NumReq-1:0] exp_gnt;
        int                exp_idx;

        rst_ni      = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        chk_addr    = '0;
        flush       = 1'b0;
        #12;
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single write from requester 0.
        req_valid[0]    = 1'b1;
        req_addr[0 +: 5] = 5'd5;
        req_data[0 +: 128] = D0;
        #1;
        check("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("single_we", rf_we, 1);
        check("single_waddr", rf_waddr, 5);
        check("single_wdata", rf_wdata, D0);
        tick();
        check("single_we_off", rf_we, 0);
        check("single_waddr_hold", rf_waddr, 5);
        check("single_wdata_hold", rf_wdata, D0);

        // Reset asserted mid-write (rr_ptr=1, so requester 1 wins).
        req_valid[1]      = 1'b1;
        req_addr[5 +: 5]  = 5'd4;
        req_data[128 +: 128] = 128'h1111;
        claim_valid = 1'b1;
        claim_addr  = 5'd6;
        #1;
        check("pre_rst_ready", req_ready, 3'b010);
        tick();
        check("pre_rst_we", rf_we, 1);
        check("pre_rst_busy", busy, 32'h40);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_we", rf_we, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", req_ready, 0);
        check("async_rst_claim", claim_ready, 0);
        req_valid   = '0;
        claim_valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("post_rst_we", rf_we, 0);

        // Fairness: all three valid for six cycles, rr_ptr=0.
        for (int r = 0; r < NumReq; r++) begin
            req_addr[r*5 +: 5]     = 5'(10 + r);
            req_data[r*128 +: 128] = 128'(32'hA000 + r);
        end
        req_valid = 3'b111;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_idx = i % 3;
            exp_gnt = 3'b001 << exp_idx;
            check($sformatf("fair_ready_%0d", i), req_ready, exp_gnt);
            tick();
            if (i == 5) req_valid = '0;
            check($sformatf("fair_we_%0d", i), rf_we, 1);
            check($sformatf("fair_waddr_%0d", i), rf_waddr, 10 + exp_idx);
            check($sformatf("fair_wdata_%0d", i), rf_wdata, 32'hA000 + exp_idx);
        end
        tick();
        check("fair_we_off", rf_we, 0);

        // Scoreboard claim and release of r7 (rr_ptr back at 0).
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        #1;
        check("claim7_ready", claim_ready, 1);
        tick();
        claim_valid = 1'b0;
        chk_addr    = {5'd0, 5'd7};
        #1;
        check("claim7_busy", busy, 32'h80);
        check("claim7_chk", chk_busy, 2'b01);
        claim_valid = 1'b1;
        #1;
        check("claim7_again", claim_ready, 0);
        claim_valid = 1'b0;
        req_valid[1]     = 1'b1;
        req_addr[5 +: 5] = 5'd7;
        #1;
        check("exec7_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        check("exec7_we", rf_we, 1);
        check("exec7_waddr", rf_waddr, 7);
        check("exec7_still_busy", busy, 32'h80);
        tick();
        check("exec7_released", busy, 0);
        check("exec7_chk", chk_busy, 2'b00);

        // Collision: claim r3 on the edge where the write to r3 clears it (rr_ptr=2).
        req_valid[2]      = 1'b1;
        req_addr[10 +: 5] = 5'd3;
        #1;
        check("coll_ready", req_ready, 3'b100);
        tick();
        req_valid   = '0;
        claim_valid = 1'b1;
        claim_addr  = 5'd3;
        #1;
        check("coll_we", rf_we, 1);
        check("coll_waddr", rf_waddr, 3);
        check("coll_claim_ready", claim_ready, 1);
        tick();
        claim_valid = 1'b0;
        check("coll_busy", busy, 32'h8);

        // Flush with r2, r3, r9 busy and requester 1 waiting (rr_ptr=0).
        claim_valid = 1'b1;
        claim_addr  = 5'd2;
        tick();
        claim_addr  = 5'd9;
        tick();
        claim_valid = 1'b0;
        chk_addr    = {5'd9, 5'd2};
        #1;
        check("pre_flush_busy", busy, 32'h20C);
        check("pre_flush_chk", chk_busy, 2'b11);
        req_valid[1]         = 1'b1;
        req_addr[5 +: 5]     = 5'd20;
        req_data[128 +: 128] = 128'hBEEF;
        claim_valid = 1'b1;
        claim_addr  = 5'd21;
        flush       = 1'b1;
        #1;
        check("flush_ready", req_ready, 0);
        check("flush_claim", claim_ready, 0);
        tick();
        flush       = 1'b0;
        claim_valid = 1'b0;
        #1;
        check("flush_busy", busy, 0);
        check("flush_we", rf_we, 0);
        check("post_flush_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        check("post_flush_we", rf_we, 1);
        check("post_flush_waddr", rf_waddr, 20);
        check("post_flush_wdata", rf_wdata, 128'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
